// File: rtl/serial_feed_pkg.sv
// Shared definitions for the serial bit feeder: FSM encoding and bits-per-word helper.
// PARITY_EN (macro) appends an even-parity bit to every word.
package serial_feed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_e;

    function automatic int unsigned nbits(int unsigned data_w);
`ifdef PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/sfb_word_fifo.sv
// Word FIFO for the serial bit feeder; power-of-two depth so pointers wrap naturally.
module sfb_word_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic [DATA_W-1:0]           wdata_i,
    input  logic                        pop_i,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]  wptr_q, wptr_d;
    logic [AddrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    // A push is refused at full even when a pop frees a slot in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AddrW'(1);
        if (do_pop)  rptr_d = rptr_q + AddrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: buffers words and streams them one bit per enabled cycle.
// Build option PARITY_EN appends the even-parity bit after each word's data bits.
module serial_bit_feeder
    import serial_feed_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bit_en,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic [1:0]        test_state
);

    localparam int unsigned Nbits = nbits(DATA_W);
    localparam int unsigned BcntW = $clog2(Nbits);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [BcntW-1:0] BcntLast = BcntW'(Nbits - 1);

    state_e            state_q, state_d;
    logic [Nbits-1:0]  shreg_q, shreg_d;
    logic [Nbits-1:0]  load_word;
    logic [BcntW-1:0]  bcnt_q, bcnt_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;

    sfb_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i (in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Parity sits at the end of the shift order so it is always the last bit sent.
    always_comb begin
`ifdef PARITY_EN
        if (MSB_FIRST != 0) load_word = {fifo_rdata, ^fifo_rdata};
        else                load_word = {^fifo_rdata, fifo_rdata};
`else
        load_word = fifo_rdata;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bcnt_q      <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bcnt_q      <= bcnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        fifo_pop    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = load_word;
                    bcnt_d   = BcntLast;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_en) begin
                    bit_valid_d = 1'b1;
                    bcnt_d      = bcnt_q - BcntW'(1);
                    if (MSB_FIRST != 0) begin
                        bit_out_d = shreg_q[Nbits-1];
                        shreg_d   = shreg_q << 1;
                    end else begin
                        bit_out_d = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                    // Reload on the last bit keeps consecutive words gap-free.
                    if (bcnt_q == '0) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shreg_d  = load_word;
                            bcnt_d   = BcntLast;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = !fifo_full;
        busy       = (state_q == ST_SHIFT) || (fifo_count != '0);
        test_state = state_q;
        bit_out    = bit_out_q;
        bit_valid  = bit_valid_q;
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances driven in parallel,
// checked against a per-bit queue model built from accepted words.
module tb_serial_bit_feeder;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
`ifdef PARITY_EN
    localparam int unsigned NB = DW + 1;
`else
    localparam int unsigned NB = DW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          bit_en;
    logic          m_in_ready, m_bit_out, m_bit_valid, m_busy;
    logic [1:0]    m_state;
    logic          l_in_ready, l_bit_out, l_bit_valid, l_busy;
    logic [1:0]    l_state;

    always #5 clk = ~clk;

    serial_bit_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (m_in_ready),
        .bit_en     (bit_en),
        .bit_out    (m_bit_out),
        .bit_valid  (m_bit_valid),
        .busy       (m_busy),
        .test_state (m_state)
    );

    serial_bit_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (l_in_ready),
        .bit_en     (bit_en),
        .bit_out    (l_bit_out),
        .bit_valid  (l_bit_valid),
        .busy       (l_busy),
        .test_state (l_state)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_vcnt = 0;
    int   l_vcnt = 0;
    int   run = 0;
    int   maxrun = 0;
    int   acc_cnt = 0;
    int   first_v = -1;
    int   acc_c;
    bit   exp_m[$];
    bit   exp_l[$];
    logic [15:0] col_m = '0;
    logic [15:0] col_l = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial order of one accepted word for both bit orders.
    task automatic record(logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) begin
            exp_m.push_back(w[DW-1-i]);
            exp_l.push_back(w[i]);
        end
`ifdef PARITY_EN
        exp_m.push_back(^w);
        exp_l.push_back(^w);
`endif
    endtask

    task automatic step();
        logic          acc, en, r;
        logic [DW-1:0] w;
        acc = in_valid && m_in_ready && !rst;
        en  = bit_en;
        r   = rst;
        w   = in_data;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            exp_m.delete();
            exp_l.delete();
        end
        if (acc) begin
            record(w);
            acc_cnt++;
        end
        if (m_bit_valid) begin
            m_vcnt++;
            run++;
            if (run > maxrun) maxrun = run;
            if (first_v < 0) first_v = cyc;
            col_m = {col_m[14:0], m_bit_out};
            chk("msb_valid_needs_en", 32'(en), 32'd1);
            chk("msb_bit_pending", 32'(exp_m.size() > 0), 32'd1);
            if (exp_m.size() > 0) chk("msb_bit", 32'(m_bit_out), 32'(exp_m.pop_front()));
        end else begin
            run = 0;
        end
        if (l_bit_valid) begin
            l_vcnt++;
            col_l = {col_l[14:0], l_bit_out};
            chk("lsb_valid_needs_en", 32'(en), 32'd1);
            chk("lsb_bit_pending", 32'(exp_l.size() > 0), 32'd1);
            if (exp_l.size() > 0) chk("lsb_bit", 32'(l_bit_out), 32'(exp_l.pop_front()));
        end
    endtask

    initial begin
        logic [NB-1:0] e_m;
        logic [NB-1:0] e_l;
        rst      = 1'b1;
        in_valid = 1'b0;
        bit_en   = 1'b0;
        in_data  = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_bit_out", 32'(m_bit_out), 32'd0);
        chk("rst_bit_valid", 32'(m_bit_valid), 32'd0);
        chk("rst_in_ready", 32'(m_in_ready), 32'd1);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_state", 32'(m_state), 32'd0);
        chk("rst_lsb_valid", 32'(l_bit_valid), 32'd0);

        // Single word 0xB6, both bit orders, latency and state.
        bit_en   = 1'b1;
        in_data  = 8'hB6;
        in_valid = 1'b1;
        first_v  = -1;
        m_vcnt   = 0;
        l_vcnt   = 0;
        acc_c    = cyc;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 2) begin
                chk("shift_state", 32'(m_state), 32'd1);
                chk("shift_busy", 32'(m_busy), 32'd1);
            end
        end
        chk("first_bit_latency", 32'(first_v - acc_c), 32'd3);
        chk("msb_bits_per_word", 32'(m_vcnt), 32'(NB));
        chk("lsb_bits_per_word", 32'(l_vcnt), 32'(NB));
`ifdef PARITY_EN
        e_m = {8'b10110110, 1'b1};
        e_l = {8'b01101101, 1'b1};
`else
        e_m = 8'b10110110;
        e_l = 8'b01101101;
`endif
        chk("msb_order_b6", 32'(col_m[NB-1:0]), 32'(e_m));
        chk("lsb_order_b6", 32'(col_l[NB-1:0]), 32'(e_l));
        chk("idle_after_word", 32'(m_state), 32'd0);
        chk("not_busy_after_word", 32'(m_busy), 32'd0);

        // Back-to-back words stream with no gap.
        maxrun   = 0;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_data  = 8'h00;
        step();
        in_valid = 1'b0;
        repeat (30) step();
        chk("no_gap_run", 32'(maxrun), 32'(2 * NB));

        // Fill while stalled: DEPTH in FIFO plus one in the shifter.
        bit_en   = 1'b0;
        in_valid = 1'b1;
        acc_cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = DW'($urandom);
            step();
        end
        chk("fill_accepted", 32'(acc_cnt), 32'(DEPTH + 1));
        chk("fill_in_ready", 32'(m_in_ready), 32'd0);
        chk("fill_busy", 32'(m_busy), 32'd1);
        in_valid = 1'b0;
        bit_en   = 1'b1;
        m_vcnt   = 0;
        repeat (5 * NB + 10) step();
        chk("fill_drained_bits", 32'(m_vcnt), 32'(5 * NB));
        chk("fill_queue_empty", 32'(exp_m.size()), 32'd0);

        // Gated enable during 0xA5.
        m_vcnt   = 0;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bit_en = i[0];
            step();
        end
        bit_en = 1'b1;
        repeat (4) step();
        chk("gated_bits", 32'(m_vcnt), 32'(NB));
`ifdef PARITY_EN
        e_m = {8'hA5, 1'b0};
`else
        e_m = 8'hA5;
`endif
        chk("gated_order", 32'(col_m[NB-1:0]), 32'(e_m));

        // Reset mid-word with words queued.
        bit_en   = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        step();
        in_data  = 8'h5A;
        step();
        in_data  = 8'h3C;
        step();
        in_valid = 1'b0;
        bit_en   = 1'b1;
        m_vcnt   = 0;
        for (int i = 0; i < 20 && m_vcnt < 3; i++) step();
        chk("pre_rst_bits", 32'(m_vcnt), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_rst_valid", 32'(m_bit_valid), 32'd0);
        chk("post_rst_busy", 32'(m_busy), 32'd0);
        chk("post_rst_in_ready", 32'(m_in_ready), 32'd1);
        chk("post_rst_state", 32'(m_state), 32'd0);
        m_vcnt = 0;
        repeat (20) step();
        chk("post_rst_silent", 32'(m_vcnt), 32'd0);

        // Parity-carrying word 0x07.
        in_data  = 8'h07;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (16) step();
`ifdef PARITY_EN
        e_m = {8'h07, 1'b1};
`else
        e_m = 8'h07;
`endif
        chk("word_07", 32'(col_m[NB-1:0]), 32'(e_m));

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            bit_en   = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        bit_en   = 1'b1;
        repeat ((DEPTH + 2) * NB + 10) step();
        chk("rand_msb_drained", 32'(exp_m.size()), 32'd0);
        chk("rand_lsb_drained", 32'(exp_l.size()), 32'd0);
        chk("rand_idle", 32'(m_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
